// File: rtl/reset_sequencer.sv
// Ordered release of NUM_STAGES downstream resets: hold all for WIDTH cycles, then release
// each stage once the previous one reports ready and has settled for DELAY cycles.
module reset_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int WIDTH      = 50,
    parameter int DELAY      = 10,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [NUM_STAGES-1:0] stage_ready_i,
    output logic [NUM_STAGES-1:0] stage_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [2:0]            fail_stage_o,
    output logic [7:0]            restart_count_o
);

    localparam int MAX_AB = (WIDTH > DELAY) ? WIDTH : DELAY;
    localparam int MAX_ALL = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
    localparam int CNT_W = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0]      WIDTH_C   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]      DELAY_C   = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0]      TIMEOUT_C = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]            LAST_C    = 3'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES  = '1;
    localparam logic [NUM_STAGES-1:0] STAGE0    = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        S_ASSERT,
        S_WAIT_READY,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q;
    logic [2:0]              k_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_STAGES-1:0]   stage_reset_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic [2:0]              fail_stage_q;
    logic [7:0]              restart_q;

    logic [NUM_STAGES-1:0]   confirmed_d;
    logic                    lost_ready_d;
    logic                    ready_cur_d;

    // Stages whose ready has already been accepted; losing any of them forces a full rerun.
    always_comb begin
        confirmed_d = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            case (state_q)
                S_WAIT_READY: confirmed_d[j] = (3'(j) < k_q);
                S_SETTLE:     confirmed_d[j] = (3'(j) <= k_q);
                S_DONE:       confirmed_d[j] = 1'b1;
                default:      confirmed_d[j] = 1'b0;
            endcase
        end
    end

    assign lost_ready_d = |(confirmed_d & ~stage_ready_i);
    assign ready_cur_d  = |(stage_ready_i & (STAGE0 << k_q));

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q       <= S_ASSERT;
            k_q           <= '0;
            cnt_q         <= '0;
            stage_reset_q <= ALL_ONES;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            fail_stage_q  <= '0;
            restart_q     <= '0;
        end else if (start_i || lost_ready_d) begin
            state_q       <= S_ASSERT;
            k_q           <= '0;
            cnt_q         <= '0;
            stage_reset_q <= ALL_ONES;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            fail_stage_q  <= '0;
            if (!start_i && restart_q != 8'hFF) begin
                restart_q <= restart_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_ASSERT: begin
                    if (cnt_q == WIDTH_C) begin
                        state_q       <= S_WAIT_READY;
                        k_q           <= '0;
                        cnt_q         <= '0;
                        stage_reset_q <= ALL_ONES << 1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_READY: begin
                    if (ready_cur_d) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q       <= S_ERROR;
                        cnt_q         <= '0;
                        stage_reset_q <= ALL_ONES;
                        busy_q        <= 1'b0;
                        error_q       <= 1'b1;
                        fail_stage_q  <= k_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Releases are always one more bit shifted in, so low bits stay contiguous.
                S_SETTLE: begin
                    if (cnt_q == DELAY_C) begin
                        cnt_q <= '0;
                        if (k_q == LAST_C) begin
                            state_q       <= S_DONE;
                            stage_reset_q <= '0;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                        end else begin
                            state_q       <= S_WAIT_READY;
                            k_q           <= k_q + 3'd1;
                            stage_reset_q <= stage_reset_q << 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE, S_ERROR: begin
                    cnt_q <= '0;
                end
                default: begin
                    state_q       <= S_ASSERT;
                    k_q           <= '0;
                    cnt_q         <= '0;
                    stage_reset_q <= ALL_ONES;
                    busy_q        <= 1'b1;
                    done_q        <= 1'b0;
                    error_q       <= 1'b0;
                end
            endcase
        end
    end

    assign stage_reset_o   = stage_reset_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign fail_stage_o    = fail_stage_q;
    assign restart_count_o = restart_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: each stage's ready rises 5 cycles after its release
// unless masked, and expected edges are hand-computed from WIDTH=50, DELAY=10, TIMEOUT=1024.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [3:0] stage_ready_i;
    logic [3:0] stage_reset_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;
    logic [2:0] fail_stage_o;
    logic [7:0] restart_count_o;

    logic [3:0] ready_model = 4'b0000;
    logic [3:0] drop_mask   = 4'b0000;
    int         low_cnt [4] = '{default: 0};
    int         checks      = 0;
    int         passes      = 0;

    reset_sequencer #(
        .NUM_STAGES(4),
        .WIDTH(50),
        .DELAY(10),
        .TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .start_i(start_i),
        .stage_ready_i(stage_ready_i),
        .stage_reset_o(stage_reset_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .error_o(error_o),
        .fail_stage_o(fail_stage_o),
        .restart_count_o(restart_count_o)
    );

    always #5 clk = ~clk;

    // Ready model: a stage reports ready from the 5th edge after its reset was seen low.
    always @(negedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (stage_reset_o[j]) low_cnt[j] = 0;
            else if (low_cnt[j] < 100) low_cnt[j] = low_cnt[j] + 1;
            ready_model[j] = (low_cnt[j] >= 5);
        end
    end

    assign stage_ready_i = ready_model & ~drop_mask;

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        wait_edges(2);
        checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL reset_stage_reset got %b expected %b", stage_reset_o, 4'b1111); else passes++;
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL reset_busy got %b expected 1", busy_o); else passes++;
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL reset_done got %b expected 0", done_o); else passes++;
        checks++; if (error_o !== 1'b0) $display("[TB] FAIL reset_error got %b expected 0", error_o); else passes++;
        checks++; if (fail_stage_o !== 3'd0) $display("[TB] FAIL reset_fail_stage got %0d expected 0", fail_stage_o); else passes++;
        checks++; if (restart_count_o !== 8'd0) $display("[TB] FAIL reset_restart got %0d expected 0", restart_count_o); else passes++;
    endtask

    task automatic test_nominal();
        reset_i = 1'b0;
        wait_edges(50);
        checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL nom_edge49 got %b expected %b", stage_reset_o, 4'b1111); else passes++;
        wait_edges(1);
        checks++; if (stage_reset_o !== 4'b1110) $display("[TB] FAIL nom_edge50 got %b expected %b", stage_reset_o, 4'b1110); else passes++;
        wait_edges(15);
        checks++; if (stage_reset_o !== 4'b1110) $display("[TB] FAIL nom_edge65 got %b expected %b", stage_reset_o, 4'b1110); else passes++;
        wait_edges(1);
        checks++; if (stage_reset_o !== 4'b1100) $display("[TB] FAIL nom_edge66 got %b expected %b", stage_reset_o, 4'b1100); else passes++;
        wait_edges(16);
        checks++; if (stage_reset_o !== 4'b1000) $display("[TB] FAIL nom_edge82 got %b expected %b", stage_reset_o, 4'b1000); else passes++;
        wait_edges(16);
        checks++; if (stage_reset_o !== 4'b0000) $display("[TB] FAIL nom_edge98 got %b expected %b", stage_reset_o, 4'b0000); else passes++;
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL nom_busy98 got %b expected 1", busy_o); else passes++;
        wait_edges(15);
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL nom_done113 got %b expected 0", done_o); else passes++;
        wait_edges(1);
        checks++; if (done_o !== 1'b1) $display("[TB] FAIL nom_done114 got %b expected 1", done_o); else passes++;
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL nom_busy114 got %b expected 0", busy_o); else passes++;
        checks++; if (stage_reset_o !== 4'b0000) $display("[TB] FAIL nom_final_resets got %b expected %b", stage_reset_o, 4'b0000); else passes++;
    endtask

    task automatic test_lost_lock();
        drop_mask = 4'b0010;
        wait_edges(1);
        drop_mask = 4'b0000;
        checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL lost_resets got %b expected %b", stage_reset_o, 4'b1111); else passes++;
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL lost_done got %b expected 0", done_o); else passes++;
        checks++; if (restart_count_o !== 8'd1) $display("[TB] FAIL lost_restart got %0d expected 1", restart_count_o); else passes++;
        wait_edges(50);
        checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL lost_rerun_hold got %b expected %b", stage_reset_o, 4'b1111); else passes++;
        wait_edges(1);
        checks++; if (stage_reset_o !== 4'b1110) $display("[TB] FAIL lost_rerun_rel0 got %b expected %b", stage_reset_o, 4'b1110); else passes++;
        wait_edges(64);
        checks++; if (done_o !== 1'b1) $display("[TB] FAIL lost_rerun_done got %b expected 1", done_o); else passes++;
        checks++; if (restart_count_o !== 8'd1) $display("[TB] FAIL lost_rerun_restart got %0d expected 1", restart_count_o); else passes++;
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1;
        wait_edges(1);
        start_i = 1'b0;
        checks++; if (restart_count_o !== 8'd1) $display("[TB] FAIL mid_start_restart got %0d expected 1", restart_count_o); else passes++;
        wait_edges(90);
        checks++; if (stage_reset_o !== 4'b1000) $display("[TB] FAIL mid_settle2 got %b expected %b", stage_reset_o, 4'b1000); else passes++;
        reset_i = 1'b1;
        wait_edges(1);
        reset_i = 1'b0;
        checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL mid_resets got %b expected %b", stage_reset_o, 4'b1111); else passes++;
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL mid_busy got %b expected 1", busy_o); else passes++;
        checks++; if (restart_count_o !== 8'd0) $display("[TB] FAIL mid_restart got %0d expected 0", restart_count_o); else passes++;
        wait_edges(50);
        checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL mid_width_hold got %b expected %b", stage_reset_o, 4'b1111); else passes++;
        wait_edges(1);
        checks++; if (stage_reset_o !== 4'b1110) $display("[TB] FAIL mid_width_rel got %b expected %b", stage_reset_o, 4'b1110); else passes++;
    endtask

    task automatic test_timeout();
        reset_i   = 1'b1;
        drop_mask = 4'b0100;
        wait_edges(2);
        reset_i = 1'b0;
        wait_edges(1106);
        checks++; if (error_o !== 1'b0) $display("[TB] FAIL to_early_error got %b expected 0", error_o); else passes++;
        checks++; if (stage_reset_o !== 4'b1000) $display("[TB] FAIL to_early_resets got %b expected %b", stage_reset_o, 4'b1000); else passes++;
        wait_edges(1);
        checks++; if (error_o !== 1'b1) $display("[TB] FAIL to_error got %b expected 1", error_o); else passes++;
        checks++; if (fail_stage_o !== 3'd2) $display("[TB] FAIL to_fail_stage got %0d expected 2", fail_stage_o); else passes++;
        checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL to_resets got %b expected %b", stage_reset_o, 4'b1111); else passes++;
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL to_busy got %b expected 0", busy_o); else passes++;
        start_i   = 1'b1;
        drop_mask = 4'b0000;
        wait_edges(1);
        start_i = 1'b0;
        checks++; if (error_o !== 1'b0) $display("[TB] FAIL to_start_error got %b expected 0", error_o); else passes++;
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL to_start_busy got %b expected 1", busy_o); else passes++;
        wait_edges(114);
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL to_rerun_early got %b expected 0", done_o); else passes++;
        wait_edges(1);
        checks++; if (done_o !== 1'b1) $display("[TB] FAIL to_rerun_done got %b expected 1", done_o); else passes++;
    endtask

    task automatic test_simultaneous();
        start_i   = 1'b1;
        drop_mask = 4'b0001;
        wait_edges(1);
        start_i   = 1'b0;
        drop_mask = 4'b0000;
        checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL sim_resets got %b expected %b", stage_reset_o, 4'b1111); else passes++;
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL sim_done got %b expected 0", done_o); else passes++;
        checks++; if (restart_count_o !== 8'd0) $display("[TB] FAIL sim_restart got %0d expected 0", restart_count_o); else passes++;
        wait_edges(115);
        checks++; if (done_o !== 1'b1) $display("[TB] FAIL sim_rerun_done got %b expected 1", done_o); else passes++;
    endtask

    task automatic test_saturation();
        int expect_cnt;
        reset_i = 1'b1;
        wait_edges(1);
        reset_i = 1'b0;
        wait_edges(56);
        for (int i = 1; i <= 300; i++) begin
            drop_mask = 4'b0001;
            wait_edges(1);
            drop_mask = 4'b0000;
            expect_cnt = (i > 255) ? 255 : i;
            if (i == 1 || i == 255 || i == 256 || i == 300) begin
                checks++; if (restart_count_o !== 8'(expect_cnt)) $display("[TB] FAIL sat_count_%0d got %0d expected %0d", i, restart_count_o, expect_cnt); else passes++;
                checks++; if (stage_reset_o !== 4'b1111) $display("[TB] FAIL sat_resets_%0d got %b expected %b", i, stage_reset_o, 4'b1111); else passes++;
            end
            wait_edges(56);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        wait_edges(3);
        test_reset();
        test_nominal();
        test_lost_lock();
        test_reset_mid();
        test_timeout();
        test_simultaneous();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences ordered release of up to NUM_STAGES downstream synchronous resets, e.g. DCM/MMCM, ADC interface, and capture/packetiser stages, in a single clock domain. Each stage is held in reset for a minimum width. It is then released in turn, and the next stage is released only after the previous one reports ready and a settle delay has elapsed. The block sits beside the board's reset_block instances in the XPS base system, driving their reset_i inputs and supervising the ready/locked indicators they gate.

## Interface
- NUM_STAGES, 4, number of sequenced stages (1..8)
- WIDTH, 50, minimum cycles all stage resets are held asserted before the first release
- DELAY, 10, settle cycles between stage k ready and stage k+1 release
- TIMEOUT, 1024, max cycles to wait for a stage's ready before declaring failure
- clk  in  1  system clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle soft request to rerun the full sequence
- stage_ready_i  in  NUM_STAGES  per-stage ready/locked, level, already synchronous to clk
- stage_reset_o  out  NUM_STAGES  per-stage reset, active-high, registered
- busy_o  out  1  sequence in progress
- done_o  out  1  all stages released and ready
- error_o  out  1  sequence aborted on timeout
- fail_stage_o  out  3  index of the stage that timed out (valid while error_o)
- restart_count_o  out  8  saturating count of automatic restarts caused by lost ready

## Operation
- States: ASSERT, WAIT_READY, SETTLE, DONE, ERROR. A stage index k and one shared cycle counter are carried across states.
- reset_i=1 forces the following at each edge:
  - state ASSERT, k=0, counter=0
  - stage_reset_o all ones, busy_o=1
  - done_o=0, error_o=0, fail_stage_o=0, restart_count_o=0
- ASSERT: all stage_reset_o high. After WIDTH cycles, stage_reset_o[0] goes low and the state moves to WAIT_READY with k=0.
- WAIT_READY: wait for stage_ready_i[k]=1.
  - On ready: go to SETTLE, counter cleared.
  - After TIMEOUT cycles without ready: go to ERROR.
- SETTLE: after DELAY cycles, one of two transitions:
  - k<NUM_STAGES-1: k increments, stage_reset_o[k+1] goes low, state returns to WAIT_READY.
  - k=NUM_STAGES-1: go to DONE.
- DONE: busy_o=0, done_o=1, all stage_reset_o low.
- ERROR: stage_reset_o all ones, error_o=1, fail_stage_o=k, busy_o=0. The block stays in ERROR until start_i or reset_i.
- Lost ready: any stage j already confirmed ready drops stage_ready_i[j] while in WAIT_READY (j<k), SETTLE (j<=k) or DONE. The block then:
  - returns to ASSERT, with all resets reasserted at the next edge;
  - increments restart_count_o, saturating at 255.
- start_i=1 in any state: return to ASSERT at the next edge and clear error_o and done_o. restart_count_o is unchanged.
- Priority per edge: reset_i > start_i > lost ready > timeout > normal progress.
- A released stage is never re-released out of order. stage_reset_o bits are always monotonic in index: bit j low implies every bit below j is low.

## Timing
- Edge 0 is the first edge with reset_i sampled low.
- stage_reset_o[0] falls after edge WIDTH.
- Ready for stage k sampled high at edge t:
  - stage_reset_o[k+1] falls after edge t+DELAY+1;
  - for the last stage, done_o rises after edge t+DELAY+1.
- Timeout: ready never seen in the TIMEOUT cycles following release. error_o rises and all resets reassert at the edge that completes the TIMEOUT-th waiting cycle.
- Lost ready or start_i sampled at edge t: all stage_reset_o are high and done_o=0 after edge t. The WIDTH count restarts at t+1.
- Registered-output latency is 1 cycle from any sampled input to its effect. There are no combinational input-to-output paths.
- Counter width is clog2(max(WIDTH, DELAY, TIMEOUT)+1) bits. The counter clears on every state change.

## Test plan
- Nominal sequence, NUM_STAGES=4, WIDTH=50, DELAY=10. Release reset_i; each stage's ready rises 5 cycles after its release.
  - stage_reset_o[0] falls after edge 50.
  - Each subsequent release occurs 11 cycles after the prior ready is sampled.
  - done_o=1 and busy_o=0 at the end, with stage_reset_o=4'b0000.
- Timeout: hold stage_ready_i[2]=0 with TIMEOUT=1024.
  - error_o=1 and fail_stage_o=2 after 1024 waiting cycles; stage_reset_o=4'b1111.
  - A subsequent start_i clears error_o and reruns the sequence to done_o.
- Lost lock in DONE: drop stage_ready_i[1] for 1 cycle.
  - The next edge gives stage_reset_o=4'b1111, done_o=0, restart_count_o=1.
  - The full sequence then reruns.
- Reset mid-operation: assert reset_i during SETTLE of stage 2.
  - All outputs take their reset values on that edge.
  - After release, the WIDTH count restarts from 0.
- Simultaneous events: start_i and a stage-0 ready drop in the same cycle while in DONE. start_i wins: ASSERT is entered and restart_count_o is not incremented.
- Saturation: force 300 lost-ready restarts. restart_count_o holds at 255.
